vga_timing_gen_multi: RTL and testbench
=======================================

Name: vga_timing_gen_multi

Overview:
Parametrised successor to the fixed-mode XGA vga_controller timing core. It generates pixel coordinates, sync, blanking and frame/line markers for two compile-time timing sets (mode 0 and mode 1). The active set is selected at runtime and changes only on a frame boundary. It sits between the pixel clock domain and the pattern/framebuffer readers, and advances only on a pixel clock-enable.

Parameters:
X_W, 11, pixel_x width
Y_W, 10, pixel_y width
FC_W, 8, frame_count width
M0_H_ACT/M0_H_FP/M0_H_SYNC/M0_H_BP, 1024/24/136/160, mode 0 horizontal timing (XGA, H_TOTAL 1344)
M0_V_ACT/M0_V_FP/M0_V_SYNC/M0_V_BP, 768/3/6/29, mode 0 vertical timing (V_TOTAL 806)
M0_HS_POL/M0_VS_POL, 0/0, mode 0 sync active level (0 = active-low)
M1_H_ACT/M1_H_FP/M1_H_SYNC/M1_H_BP, 800/40/128/88, mode 1 horizontal timing (SVGA, H_TOTAL 1056)
M1_V_ACT/M1_V_FP/M1_V_SYNC/M1_V_BP, 600/1/4/23, mode 1 vertical timing (V_TOTAL 628)
M1_HS_POL/M1_VS_POL, 1/1, mode 1 sync active level

Ports:
clk  input  1  pixel-domain clock
reset  input  1  synchronous, active-high reset
pix_en  input  1  pixel advance enable; tie high for 1 pixel per clk
mode_sel  input  1  requested timing set; sampled only at frame wrap
pixel_x  output  X_W  current horizontal position, 0..H_TOTAL-1
pixel_y  output  Y_W  current vertical position, 0..V_TOTAL-1
hsync  output  1  horizontal sync at the active mode's polarity
vsync  output  1  vertical sync at the active mode's polarity
video_on  output  1  high when pixel_x < H_ACT and pixel_y < V_ACT
line_start  output  1  one-clk pulse when pixel_x becomes 0
frame_start  output  1  one-clk pulse when position becomes (0,0)
frame_count  output  FC_W  count of frame_start events since reset; wraps
active_mode  output  1  timing set currently in use

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high and overrides pix_en.
- Reset values: pixel_x=0, pixel_y=0, video_on=0, line_start=0, frame_start=0, frame_count=0, active_mode=0; hsync/vsync at mode 0 inactive level (1 with defaults).
- Internal position at reset = (M0 H_TOTAL-1, M0 V_TOTAL-1). The first pix_en after reset wraps to (0,0) and asserts frame_start, line_start and video_on.
- All outputs are flops. hsync, vsync, video_on, line_start and frame_start always describe the same position as the current pixel_x/pixel_y, so the decode is done on the next position.
- pix_en=0: position and all level outputs hold; line_start and frame_start are 0. The pulses are exactly 1 clk, never stretched across pix_en gaps.
- Horizontal (pix_en=1): x increments each enable. At x = H_TOTAL-1, x goes to 0 and y increments. At (H_TOTAL-1, V_TOTAL-1), the next position is (0,0).
- hsync is active for x in [H_ACT+H_FP, H_ACT+H_FP+H_SYNC-1]. vsync is active for y in [V_ACT+V_FP, V_ACT+V_FP+V_SYNC-1]. vsync changes together with the x=0 transition.
- Mode switch: mode_sel is sampled only on the frame-wrap transition. active_mode and all timing limits and polarities switch in the same clk that shows (0,0). mode_sel changes mid-frame have no effect. No partial frame is ever produced.
- frame_count increments by 1 on every frame_start, including the first after reset, and wraps 2^FC_W-1 -> 0.
- Reset mid-frame: the next clk shows reset values regardless of mode or pix_en; active_mode returns to 0.
- Elaboration: $error if X_W cannot hold max(H_TOTAL)-1, or Y_W cannot hold max(V_TOTAL)-1, or any porch/sync parameter is 0.
- No combinational path from inputs to outputs.

Test Plan:
- Mode 0, pix_en=1, mode_sel=0: line period 1344 clk; video_on high for x 0..1023; hsync=0 exactly for x 1048..1183 (136 clk); vsync=0 for y 771..776; frame_start period 1,083,264 clk.
- Raise mode_sel=1 at y=400 of frame 2: frame 2 completes in mode 0 timing; frame 3 shows active_mode=1, line period 1056, hsync=1 for x 840..967, vsync=1 for y 601..604, frame period 663,168 clk.
- pix_en toggling 1,0,1,0: all periods double in clk; line_start and frame_start remain single-clk wide; the position holds on pix_en=0 cycles.
- Reset asserted for one clk at mode 1, position (500,300): next clk shows pixel_x=0, pixel_y=0, video_on=0, hsync=vsync=1, active_mode=0. The first pix_en after reset gives frame_start=1, frame_count=1.
- Override mode 0 to H 8/1/2/1 and V 4/1/1/1 (frame period 84 clk), FC_W=8: after 255 frames frame_count=255; the 256th frame_start gives frame_count=0.
- Assertions run throughout: video_on never high during sync; pixel_x < H_TOTAL; pixel_y < V_TOTAL; exactly one frame_start per V_TOTAL line_starts.

Source files
------------

// File: rtl/vga_timing_gen_multi.sv
// vga_timing_gen_multi
//
// Pixel timing generator with two compile-time timing sets (mode 0 and mode 1).
// The active set is chosen from mode_sel only when the scan wraps from the last
// position of a frame back to (0,0), so every frame is complete in one mode.
// The position advances only on cycles with pix_en high.
//
// Ports:
//   clk          pixel-domain clock
//   reset        synchronous active-high reset (overrides pix_en)
//   pix_en       pixel advance enable
//   mode_sel     requested timing set, sampled at frame wrap only
//   pixel_x      current horizontal position, 0..H_TOTAL-1
//   pixel_y      current vertical position, 0..V_TOTAL-1
//   hsync        horizontal sync at the active mode's polarity
//   vsync        vertical sync at the active mode's polarity
//   video_on     high inside the active area
//   line_start   one-clk pulse when pixel_x becomes 0
//   frame_start  one-clk pulse when the position becomes (0,0)
//   frame_count  number of frame_start pulses since reset (wraps)
//   active_mode  timing set currently in use
//
// Every output is a flop. The sync/blank/marker decode is done on the next
// position so that all outputs describe the same pixel as pixel_x/pixel_y.

module vga_timing_gen_multi #(
    parameter int unsigned X_W       = 11,
    parameter int unsigned Y_W       = 10,
    parameter int unsigned FC_W      = 8,
    parameter int unsigned M0_H_ACT  = 1024,
    parameter int unsigned M0_H_FP   = 24,
    parameter int unsigned M0_H_SYNC = 136,
    parameter int unsigned M0_H_BP   = 160,
    parameter int unsigned M0_V_ACT  = 768,
    parameter int unsigned M0_V_FP   = 3,
    parameter int unsigned M0_V_SYNC = 6,
    parameter int unsigned M0_V_BP   = 29,
    parameter bit          M0_HS_POL = 1'b0,
    parameter bit          M0_VS_POL = 1'b0,
    parameter int unsigned M1_H_ACT  = 800,
    parameter int unsigned M1_H_FP   = 40,
    parameter int unsigned M1_H_SYNC = 128,
    parameter int unsigned M1_H_BP   = 88,
    parameter int unsigned M1_V_ACT  = 600,
    parameter int unsigned M1_V_FP   = 1,
    parameter int unsigned M1_V_SYNC = 4,
    parameter int unsigned M1_V_BP   = 23,
    parameter bit          M1_HS_POL = 1'b1,
    parameter bit          M1_VS_POL = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pix_en,
    input  logic            mode_sel,
    output logic [X_W-1:0]  pixel_x,
    output logic [Y_W-1:0]  pixel_y,
    output logic            hsync,
    output logic            vsync,
    output logic            video_on,
    output logic            line_start,
    output logic            frame_start,
    output logic [FC_W-1:0] frame_count,
    output logic            active_mode
);

    localparam int unsigned M0_H_TOTAL = M0_H_ACT + M0_H_FP + M0_H_SYNC + M0_H_BP;
    localparam int unsigned M0_V_TOTAL = M0_V_ACT + M0_V_FP + M0_V_SYNC + M0_V_BP;
    localparam int unsigned M1_H_TOTAL = M1_H_ACT + M1_H_FP + M1_H_SYNC + M1_H_BP;
    localparam int unsigned M1_V_TOTAL = M1_V_ACT + M1_V_FP + M1_V_SYNC + M1_V_BP;
    localparam int unsigned H_TOTAL_MAX = (M0_H_TOTAL > M1_H_TOTAL) ? M0_H_TOTAL : M1_H_TOTAL;
    localparam int unsigned V_TOTAL_MAX = (M0_V_TOTAL > M1_V_TOTAL) ? M0_V_TOTAL : M1_V_TOTAL;

    if (longint'(H_TOTAL_MAX) > (longint'(1) << X_W)) begin : g_x_w_check
        $error("X_W cannot hold the largest H_TOTAL-1");
    end
    if (longint'(V_TOTAL_MAX) > (longint'(1) << Y_W)) begin : g_y_w_check
        $error("Y_W cannot hold the largest V_TOTAL-1");
    end
    if (M0_H_FP == 0 || M0_H_SYNC == 0 || M0_H_BP == 0 ||
        M0_V_FP == 0 || M0_V_SYNC == 0 || M0_V_BP == 0 ||
        M1_H_FP == 0 || M1_H_SYNC == 0 || M1_H_BP == 0 ||
        M1_V_FP == 0 || M1_V_SYNC == 0 || M1_V_BP == 0) begin : g_zero_check
        $error("porch and sync parameters must be non-zero");
    end

    // Decode limits sized to the position counters.
    localparam logic [X_W-1:0] M0_H_LAST   = X_W'(M0_H_TOTAL - 1);
    localparam logic [X_W-1:0] M0_HA       = X_W'(M0_H_ACT);
    localparam logic [X_W-1:0] M0_HS_FIRST = X_W'(M0_H_ACT + M0_H_FP);
    localparam logic [X_W-1:0] M0_HS_LAST  = X_W'(M0_H_ACT + M0_H_FP + M0_H_SYNC - 1);
    localparam logic [Y_W-1:0] M0_V_LAST   = Y_W'(M0_V_TOTAL - 1);
    localparam logic [Y_W-1:0] M0_VA       = Y_W'(M0_V_ACT);
    localparam logic [Y_W-1:0] M0_VS_FIRST = Y_W'(M0_V_ACT + M0_V_FP);
    localparam logic [Y_W-1:0] M0_VS_LAST  = Y_W'(M0_V_ACT + M0_V_FP + M0_V_SYNC - 1);
    localparam logic [X_W-1:0] M1_H_LAST   = X_W'(M1_H_TOTAL - 1);
    localparam logic [X_W-1:0] M1_HA       = X_W'(M1_H_ACT);
    localparam logic [X_W-1:0] M1_HS_FIRST = X_W'(M1_H_ACT + M1_H_FP);
    localparam logic [X_W-1:0] M1_HS_LAST  = X_W'(M1_H_ACT + M1_H_FP + M1_H_SYNC - 1);
    localparam logic [Y_W-1:0] M1_V_LAST   = Y_W'(M1_V_TOTAL - 1);
    localparam logic [Y_W-1:0] M1_VA       = Y_W'(M1_V_ACT);
    localparam logic [Y_W-1:0] M1_VS_FIRST = Y_W'(M1_V_ACT + M1_V_FP);
    localparam logic [Y_W-1:0] M1_VS_LAST  = Y_W'(M1_V_ACT + M1_V_FP + M1_V_SYNC - 1);

    // Internal scan position. It differs from pixel_x/pixel_y only after reset,
    // where it parks on the last position so the first enable wraps to (0,0).
    logic [X_W-1:0] cur_x_q;
    logic [Y_W-1:0] cur_y_q;

    logic [X_W-1:0] h_last, next_x, n_h_act, n_hs_first, n_hs_last;
    logic [Y_W-1:0] v_last, next_y, n_v_act, n_vs_first, n_vs_last;
    logic           x_wrap, y_wrap, frame_wrap, next_mode, n_hs_pol, n_vs_pol;
    logic           next_hsync, next_vsync, next_video_on;

    always_comb begin
        h_last     = active_mode ? M1_H_LAST : M0_H_LAST;
        v_last     = active_mode ? M1_V_LAST : M0_V_LAST;
        x_wrap     = (cur_x_q == h_last);
        y_wrap     = (cur_y_q == v_last);
        frame_wrap = x_wrap && y_wrap;
        next_mode  = frame_wrap ? mode_sel : active_mode;

        next_x = x_wrap ? '0 : cur_x_q + X_W'(1);
        next_y = cur_y_q;
        if (x_wrap) begin
            next_y = y_wrap ? '0 : cur_y_q + Y_W'(1);
        end

        // Decode uses the mode of the next position so a switch lands on (0,0).
        n_h_act    = next_mode ? M1_HA       : M0_HA;
        n_hs_first = next_mode ? M1_HS_FIRST : M0_HS_FIRST;
        n_hs_last  = next_mode ? M1_HS_LAST  : M0_HS_LAST;
        n_v_act    = next_mode ? M1_VA       : M0_VA;
        n_vs_first = next_mode ? M1_VS_FIRST : M0_VS_FIRST;
        n_vs_last  = next_mode ? M1_VS_LAST  : M0_VS_LAST;
        n_hs_pol   = next_mode ? M1_HS_POL   : M0_HS_POL;
        n_vs_pol   = next_mode ? M1_VS_POL   : M0_VS_POL;

        next_hsync    = ((next_x >= n_hs_first) && (next_x <= n_hs_last)) ? n_hs_pol : ~n_hs_pol;
        next_vsync    = ((next_y >= n_vs_first) && (next_y <= n_vs_last)) ? n_vs_pol : ~n_vs_pol;
        next_video_on = (next_x < n_h_act) && (next_y < n_v_act);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_x_q     <= M0_H_LAST;
            cur_y_q     <= M0_V_LAST;
            pixel_x     <= '0;
            pixel_y     <= '0;
            hsync       <= ~M0_HS_POL;
            vsync       <= ~M0_VS_POL;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
            active_mode <= 1'b0;
        end else begin
            // Pulses drop on any non-advancing cycle so they never stretch.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                cur_x_q     <= next_x;
                cur_y_q     <= next_y;
                pixel_x     <= next_x;
                pixel_y     <= next_y;
                hsync       <= next_hsync;
                vsync       <= next_vsync;
                video_on    <= next_video_on;
                line_start  <= x_wrap;
                frame_start <= frame_wrap;
                active_mode <= next_mode;
                if (frame_wrap) begin
                    frame_count <= frame_count + FC_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen_multi.sv
// Bench for vga_timing_gen_multi. Two instances: one with default XGA/SVGA
// timing (a few lines only) and one with tiny timings for whole-frame tests.
// A scan-position model predicts every output on every cycle.

module tb_vga_timing_gen_multi;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        bit hp, vp;
    } tim_t;

    typedef struct {
        int x, y, fc;
        bit mode, ls, fs, fresh;
    } mst_t;

    localparam tim_t BT0 = '{1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0};
    localparam tim_t BT1 = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};
    localparam tim_t ST0 = '{8, 1, 2, 1, 4, 1, 1, 1, 1'b0, 1'b0};
    localparam tim_t ST1 = '{5, 1, 2, 2, 3, 1, 1, 2, 1'b1, 1'b1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Big instance
    logic b_reset = 1'b1, b_en = 1'b0, b_sel = 1'b0;
    logic [10:0] b_px;
    logic [9:0]  b_py;
    logic        b_hs, b_vs, b_von, b_ls, b_fs, b_am;
    logic [7:0]  b_fc;

    vga_timing_gen_multi dut_big (
        .clk(clk), .reset(b_reset), .pix_en(b_en), .mode_sel(b_sel),
        .pixel_x(b_px), .pixel_y(b_py), .hsync(b_hs), .vsync(b_vs),
        .video_on(b_von), .line_start(b_ls), .frame_start(b_fs),
        .frame_count(b_fc), .active_mode(b_am)
    );

    // Small instance
    logic s_reset = 1'b1, s_en = 1'b0, s_sel = 1'b0;
    logic [10:0] s_px;
    logic [9:0]  s_py;
    logic        s_hs, s_vs, s_von, s_ls, s_fs, s_am;
    logic [7:0]  s_fc;

    vga_timing_gen_multi #(
        .M0_H_ACT(8), .M0_H_FP(1), .M0_H_SYNC(2), .M0_H_BP(1),
        .M0_V_ACT(4), .M0_V_FP(1), .M0_V_SYNC(1), .M0_V_BP(1),
        .M1_H_ACT(5), .M1_H_FP(1), .M1_H_SYNC(2), .M1_H_BP(2),
        .M1_V_ACT(3), .M1_V_FP(1), .M1_V_SYNC(1), .M1_V_BP(2)
    ) dut_small (
        .clk(clk), .reset(s_reset), .pix_en(s_en), .mode_sel(s_sel),
        .pixel_x(s_px), .pixel_y(s_py), .hsync(s_hs), .vsync(s_vs),
        .video_on(s_von), .line_start(s_ls), .frame_start(s_fs),
        .frame_count(s_fc), .active_mode(s_am)
    );

    function automatic int htot(tim_t t);
        return t.ha + t.hf + t.hs + t.hb;
    endfunction

    function automatic int vtot(tim_t t);
        return t.va + t.vf + t.vs + t.vb;
    endfunction

    // Advance the model scan position by one clock.
    function automatic mst_t mstep(mst_t s, tim_t t0, tim_t t1, bit rst, bit en, bit sel);
        mst_t n;
        tim_t t;
        n = s;
        t = s.mode ? t1 : t0;
        n.ls = 1'b0;
        n.fs = 1'b0;
        if (rst) begin
            n.x = htot(t0) - 1;
            n.y = vtot(t0) - 1;
            n.mode = 1'b0;
            n.fc = 0;
            n.fresh = 1'b1;
        end else if (en) begin
            n.fresh = 1'b0;
            n.x = s.x + 1;
            if (n.x == htot(t)) begin
                n.x = 0;
                n.ls = 1'b1;
                n.y = s.y + 1;
                if (n.y == vtot(t)) begin
                    n.y = 0;
                    n.fs = 1'b1;
                    n.mode = sel;
                    n.fc = (s.fc + 1) % 256;
                end
            end
        end
        return n;
    endfunction

    mst_t bm, sm;
    bit bvalid = 1'b0, svalid = 1'b0;

    always @(posedge clk) begin
        bm <= mstep(bm, BT0, BT1, b_reset, b_en, b_sel);
        sm <= mstep(sm, ST0, ST1, s_reset, s_en, s_sel);
        bvalid <= bvalid | b_reset;
        svalid <= svalid | s_reset;
    end

    task automatic chk(string name, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_all(string tag, mst_t s, tim_t t0, tim_t t1,
                           int px, int py, int hs, int vs, int von,
                           int ls, int fs, int fc, int am);
        tim_t t, ta;
        int ehs, evs, evon;
        t = s.mode ? t1 : t0;
        ta = (am != 0) ? t1 : t0;
        ehs = (!s.fresh && s.x >= t.ha + t.hf && s.x < t.ha + t.hf + t.hs) ? int'(t.hp)
                                                                          : int'(!t.hp);
        evs = (!s.fresh && s.y >= t.va + t.vf && s.y < t.va + t.vf + t.vs) ? int'(t.vp)
                                                                          : int'(!t.vp);
        evon = (!s.fresh && s.x < t.ha && s.y < t.va) ? 1 : 0;
        chk({tag, ".pixel_x"}, px, s.fresh ? 0 : s.x);
        chk({tag, ".pixel_y"}, py, s.fresh ? 0 : s.y);
        chk({tag, ".hsync"}, hs, ehs);
        chk({tag, ".vsync"}, vs, evs);
        chk({tag, ".video_on"}, von, evon);
        chk({tag, ".line_start"}, ls, int'(s.ls));
        chk({tag, ".frame_start"}, fs, int'(s.fs));
        chk({tag, ".frame_count"}, fc, s.fc);
        chk({tag, ".active_mode"}, am, int'(s.mode));
        // Structural rules, judged from the DUT's own mode.
        chk({tag, ".video_in_sync"},
            int'((von != 0) && ((hs == int'(ta.hp)) || (vs == int'(ta.vp)))), 0);
        chk({tag, ".x_range"}, int'(px < htot(ta)), 1);
        chk({tag, ".y_range"}, int'(py < vtot(ta)), 1);
        chk({tag, ".fs_implies_ls"}, int'((fs != 0) && (ls == 0)), 0);
    endtask

    // Per-cycle compare and line-per-frame counting.
    initial begin
        int lcnt, prev_vt;
        bit seen;
        lcnt = 0;
        prev_vt = 0;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (bvalid)
                cmp_all("big", bm, BT0, BT1, b_px, b_py, b_hs, b_vs, b_von,
                        b_ls, b_fs, b_fc, b_am);
            if (svalid) begin
                cmp_all("small", sm, ST0, ST1, s_px, s_py, s_hs, s_vs, s_von,
                        s_ls, s_fs, s_fc, s_am);
                if (sm.fresh) begin
                    seen = 1'b0;
                    lcnt = 0;
                end
                if (s_ls) lcnt++;
                if (s_fs) begin
                    if (seen) chk("small.lines_per_frame", lcnt, prev_vt);
                    prev_vt = s_am ? vtot(ST1) : vtot(ST0);
                    lcnt = 0;
                    seen = 1'b1;
                end
            end
        end
    end

    task automatic timeout(string name);
        compared++;
        mismatched++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    task automatic wait_fs(output int c);
        c = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (s_fs) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) timeout("wait_frame_start");
    endtask

    task automatic wait_py(input int y);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (int'(s_py) == y) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) timeout("wait_pixel_y");
    endtask

    initial begin
        int ls_n, hs_low, von_n, hs_fall_x, c1, c2, f1, f2;
        int ls_c[2];
        bit prev_hs;

        // ---------------- big instance: XGA line timing ----------------
        @(negedge clk);
        @(negedge clk);
        b_reset = 1'b0;
        chk("big.reset_hsync", b_hs, 1);
        chk("big.reset_vsync", b_vs, 1);
        b_en = 1'b1;
        ls_n = 0; hs_low = 0; von_n = 0; hs_fall_x = -1; prev_hs = 1'b1;
        ls_c[0] = 0; ls_c[1] = 0;
        for (int i = 0; i < 2800; i++) begin
            @(negedge clk);
            if (b_ls) begin
                if (ls_n < 2) ls_c[ls_n] = cyc;
                ls_n++;
            end
            if (ls_n == 1) begin
                if (!b_hs) hs_low++;
                if (b_von) von_n++;
                if (prev_hs && !b_hs && hs_fall_x < 0) hs_fall_x = b_px;
            end
            prev_hs = b_hs;
        end
        b_en = 1'b0;
        chk("big.line_period", ls_c[1] - ls_c[0], 1344);
        chk("big.hsync_low_len", hs_low, 136);
        chk("big.hsync_first_x", hs_fall_x, 1048);
        chk("big.video_on_len", von_n, 1024);

        // ---------------- small instance ----------------
        s_reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        s_reset = 1'b0;
        chk("small.reset_px", s_px, 0);
        chk("small.reset_hs", s_hs, 1);
        chk("small.reset_vs", s_vs, 1);
        chk("small.reset_von", s_von, 0);
        s_en = 1'b1;
        @(negedge clk);
        chk("small.first_fs", s_fs, 1);
        chk("small.first_fc", s_fc, 1);
        chk("small.first_von", s_von, 1);

        wait_fs(c1);
        wait_fs(c2);
        chk("small.m0_frame_period", c2 - c1, 84);

        // Request mode 1 mid-frame; the current frame must finish in mode 0.
        wait_py(2);
        s_sel = 1'b1;
        chk("small.mode_before_wrap", s_am, 0);
        wait_fs(c1);
        chk("small.mode_after_wrap", s_am, 1);
        chk("small.switch_frame_period", c1 - c2, 84);
        wait_fs(c2);
        chk("small.m1_frame_period", c2 - c1, 70);

        // pix_en toggling doubles the frame period.
        f1 = -1; f2 = -1;
        for (int i = 0; i < 320; i++) begin
            @(negedge clk);
            if (s_fs) begin
                if (f1 < 0) f1 = cyc;
                else if (f2 < 0) f2 = cyc;
            end
            s_en = (i % 2 == 0) ? 1'b0 : 1'b1;
        end
        chk("small.toggle_frame_period", f2 - f1, 140);
        s_en = 1'b1;

        // Reset mid-frame while in mode 1.
        wait_py(3);
        chk("small.mode_before_reset", s_am, 1);
        s_reset = 1'b1;
        s_sel = 1'b0;
        @(negedge clk);
        s_reset = 1'b0;
        chk("small.midreset_px", s_px, 0);
        chk("small.midreset_py", s_py, 0);
        chk("small.midreset_von", s_von, 0);
        chk("small.midreset_hs", s_hs, 1);
        chk("small.midreset_vs", s_vs, 1);
        chk("small.midreset_mode", s_am, 0);
        @(negedge clk);
        chk("small.postreset_fs", s_fs, 1);
        chk("small.postreset_fc", s_fc, 1);

        // frame_count wrap.
        for (int i = 0; i < 254; i++) wait_fs(c1);
        chk("small.fc_255", s_fc, 255);
        wait_fs(c2);
        chk("small.fc_wrap", s_fc, 0);
        chk("small.wrap_period", c2 - c1, 84);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
